neuron_linear_bp: RTL and testbench

- Backward-pass counterpart of the two-input linear neuron forward datapath. The forward path computes y = sum(x*w) + b; this block computes the opposite direction.
- Given the upstream error delta = dL/dy, it computes:
  - input gradients dx[i] = delta*w[i] for the previous layer;
  - SGD-updated weights w_new[i] = w[i] - lr*delta*x[i];
  - updated bias b_new = b - lr*delta.
- Uses a start/busy/done handshake and time-multiplexes two signed fixed-point multipliers across the N inputs.

---
 rtl/neuron_linear_bp.sv | 175 +++++++++++++++++
 tb/tb_neuron_linear_bp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_linear_bp.sv
// ---------------------------------------------------------------------------
// neuron_linear_bp
// Backward pass of a linear neuron y = sum(x[i]*w[i]) + b.
// Given the upstream error delta = dL/dy it produces:
//   dx[i]    = delta * w[i]            (gradient for the previous layer)
//   w_new[i] = w[i] - lr * delta * x[i] (SGD weight update)
//   b_new    = b - lr * delta           (SGD bias update)
// All values are signed fixed point with FRAC fractional bits. Products are
// floored (arithmetic shift) and saturated; subtractions are saturated.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   BP            start strobe, only looked at while idle
//   x, w, b       forward-pass inputs, current weights and bias
//   delta, lr     upstream error and learning rate
//   busy          high while an operation is in progress
//   done          one-cycle pulse when dx / w_new / b_new are valid
//   dx, w_new     per-input gradients and updated weights
//   b_new         updated bias
//   fsm_state     current controller state, for observation only
//
// Handshake: BP is accepted only on an edge where the block is idle (busy=0);
// a request while busy is dropped, never queued. Results are valid from the
// cycle done=1 and hold until the next operation overwrites them.
// ---------------------------------------------------------------------------
module neuron_linear_bp #(
    parameter int N    = 2,
    parameter int BITS = 16,
    parameter int FRAC = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     BP,
    input  logic [N-1:0][BITS-1:0]   x,
    input  logic [N-1:0][BITS-1:0]   w,
    input  logic [BITS-1:0]          b,
    input  logic [BITS-1:0]          delta,
    input  logic [BITS-1:0]          lr,
    output logic                     busy,
    output logic                     done,
    output logic [N-1:0][BITS-1:0]   dx,
    output logic [N-1:0][BITS-1:0]   w_new,
    output logic [BITS-1:0]          b_new,
    output logic [2:0]               fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_G    = 3'd1,  // gradient g = delta*x[i], dx[i] = delta*w[i]
        S_S    = 3'd2,  // step = lr*g
        S_U    = 3'd3,  // w_new[i] = w[i] - step
        S_BS   = 3'd4,  // step = lr*delta
        S_BU   = 3'd5,  // b_new = b - step
        S_DN   = 3'd6   // done pulse
    } state_t;

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    localparam logic [BITS-1:0] SAT_MAX = {1'b0, {(BITS-1){1'b1}}};
    localparam logic [BITS-1:0] SAT_MIN = {1'b1, {(BITS-1){1'b0}}};

    state_t                    state;
    logic [IW-1:0]             idx;
    logic [N-1:0][BITS-1:0]    x_r;
    logic [N-1:0][BITS-1:0]    w_r;
    logic [BITS-1:0]           b_r;
    logic [BITS-1:0]           d_r;
    logic [BITS-1:0]           lr_r;
    logic [BITS-1:0]           g_r;
    logic [BITS-1:0]           step_r;

    // Fixed-point multiply: full-width signed product, floor by FRAC bits,
    // then saturate. The result fits in BITS bits only when the top BITS+1
    // bits of the shifted product are all copies of the sign.
    function automatic logic [BITS-1:0] mul(input logic [BITS-1:0] a,
                                            input logic [BITS-1:0] c);
        logic signed [2*BITS-1:0] ae;
        logic signed [2*BITS-1:0] ce;
        logic signed [2*BITS-1:0] p;
        ae = {{BITS{a[BITS-1]}}, a};
        ce = {{BITS{c[BITS-1]}}, c};
        p  = ae * ce;
        p  = p >>> FRAC;
        if ((&p[2*BITS-1:BITS-1]) || !(|p[2*BITS-1:BITS-1]))
            return p[BITS-1:0];
        else
            return p[2*BITS-1] ? SAT_MIN : SAT_MAX;
    endfunction

    // Saturating subtract a - c using one guard bit.
    function automatic logic [BITS-1:0] sub(input logic [BITS-1:0] a,
                                            input logic [BITS-1:0] c);
        logic [BITS:0] d;
        d = {a[BITS-1], a} - {c[BITS-1], c};
        if (d[BITS] == d[BITS-1])
            return d[BITS-1:0];
        else
            return d[BITS] ? SAT_MIN : SAT_MAX;
    endfunction

    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dx     <= '0;
            w_new  <= '0;
            b_new  <= '0;
            x_r    <= '0;
            w_r    <= '0;
            b_r    <= '0;
            d_r    <= '0;
            lr_r   <= '0;
            g_r    <= '0;
            step_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (BP) begin
                        x_r   <= x;
                        w_r   <= w;
                        b_r   <= b;
                        d_r   <= delta;
                        lr_r  <= lr;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_G;
                    end
                end
                S_G: begin
                    g_r     <= mul(d_r, x_r[idx]);
                    dx[idx] <= mul(d_r, w_r[idx]);
                    state   <= S_S;
                end
                S_S: begin
                    step_r <= mul(lr_r, g_r);
                    state  <= S_U;
                end
                S_U: begin
                    w_new[idx] <= sub(w_r[idx], step_r);
                    if (idx == LAST) begin
                        state <= S_BS;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_G;
                    end
                end
                S_BS: begin
                    step_r <= mul(lr_r, d_r);
                    state  <= S_BU;
                end
                S_BU: begin
                    b_new <= sub(b_r, step_r);
                    done  <= 1'b1;
                    state <= S_DN;
                end
                S_DN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_linear_bp.sv
module tb_neuron_linear_bp;
  localparam int N    = 2;
  localparam int BITS = 16;
  localparam int FRAC = 8;
  localparam int W    = (2*N+1)*BITS;
  localparam int LAT  = 3*N+2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                   BP;
  logic [N-1:0][BITS-1:0] x, w;
  logic [BITS-1:0]        b, delta, lr;
  logic                   busy, done;
  logic [N-1:0][BITS-1:0] dx, w_new;
  logic [BITS-1:0]        b_new;
  logic [2:0]             fsm_state;

  neuron_linear_bp #(.N(N), .BITS(BITS), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .BP(BP),
    .x(x), .w(w), .b(b), .delta(delta), .lr(lr),
    .busy(busy), .done(done),
    .dx(dx), .w_new(w_new), .b_new(b_new),
    .fsm_state(fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  // ---------------- reference model ----------------
  function automatic longint sat(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (BITS-1)) - 1;
    lo = -(longint'(1) <<< (BITS-1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // real-valued product a*c / 2^FRAC rounded down, then clamped
  function automatic longint fmul(input longint a, input longint c);
    longint p, s, q;
    p = a * c;
    s = longint'(1) <<< FRAC;
    q = p / s;
    if (p < 0 && q * s != p) q = q - 1;
    return sat(q);
  endfunction

  function automatic longint sval(input logic [BITS-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [W-1:0] model(input logic [N*BITS-1:0] xi,
                                         input logic [N*BITS-1:0] wi,
                                         input logic [BITS-1:0] bi,
                                         input logic [BITS-1:0] di,
                                         input logic [BITS-1:0] li);
    logic [N*BITS-1:0] dxe, wne;
    logic [BITS-1:0]   bne;
    longint g;
    for (int i = 0; i < N; i++) begin
      dxe[i*BITS +: BITS] = BITS'(fmul(sval(di), sval(wi[i*BITS +: BITS])));
      g = fmul(sval(di), sval(xi[i*BITS +: BITS]));
      wne[i*BITS +: BITS] = BITS'(sat(sval(wi[i*BITS +: BITS]) - fmul(sval(li), g)));
    end
    bne = BITS'(sat(sval(bi) - fmul(sval(li), sval(di))));
    return {bne, wne, dxe};
  endfunction

  // ---------------- checkers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] mon_exp;
  int           mon_cyc;
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        chk("result", {b_new, w_new, dx}, mon_exp);
        chk_int("done_cycle", cyc, mon_cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk_int("idle_timeout", 1, 0);
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      x[i] = BITS'($urandom);
      w[i] = BITS'($urandom);
    end
    b = BITS'($urandom); delta = BITS'($urandom); lr = BITS'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic [N*BITS-1:0] xi, input logic [N*BITS-1:0] wi,
                       input logic [BITS-1:0] bi, input logic [BITS-1:0] di,
                       input logic [BITS-1:0] li);
    wait_idle();
    x = xi; w = wi; b = bi; delta = di; lr = li; BP = 1'b1;
    @(posedge clk); #1;
    chk_int("busy_after_start", int'(busy), 1);
    exp_q.push_back(model(xi, wi, bi, di, li));
    exp_cyc_q.push_back(cyc + LAT);
    @(negedge clk);
    BP = 1'b0;
    scramble();
  endtask

  function automatic logic [BITS-1:0] rnd_word();
    case ($urandom_range(0, 3))
      0: return BITS'($urandom);
      1: return BITS'($urandom_range(0, 1023)) - BITS'(512);
      2: case ($urandom_range(0, 3))
           0: return 16'h7FFF;
           1: return 16'h8000;
           2: return 16'h7F00;
           default: return 16'h0100;
         endcase
      default: return '0;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n, dc;
    logic [N*BITS-1:0] rx, rw;

    BP = 1'b0; x = '0; w = '0; b = '0; delta = '0; lr = '0;
    #12;
    chk("reset_outputs", W'({busy, done, fsm_state, b_new, w_new, dx}), '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // nominal Q8.8 example
    issue({16'hFF00, 16'h0200}, {16'h0040, 16'h0080}, 16'h0100, 16'h0100, 16'h0080);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk_int("busy_len", n, LAT + 1);
    chk("nominal_dx", W'(dx), W'(32'h0040_0080));
    chk("nominal_w_new", W'(w_new), W'(32'h00C0_FF80));
    chk("nominal_b_new", W'(b_new), W'(16'h0080));

    // saturation
    issue({16'h0000, 16'h7F00}, {16'h0000, 16'h8000}, 16'h0000, 16'h7F00, 16'h0100);
    wait_idle();
    chk("sat_w_new0", W'(w_new[0]), W'(16'h8000));
    chk("sat_dx0", W'(dx[0]), W'(16'h8000));

    // truncation toward minus infinity
    issue({16'h0000, 16'h0001}, {16'h0000, 16'h1234}, 16'h0000, 16'h0001, 16'h0100);
    wait_idle();
    chk("trunc_small_w_new0", W'(w_new[0]), W'(16'h1234));
    issue({16'h0000, 16'h0001}, {16'h0000, 16'h0000}, 16'h0000, 16'hFFFF, 16'h0100);
    wait_idle();
    chk("trunc_neg_w_new0", W'(w_new[0]), W'(16'h0001));
    issue({16'h0000, 16'h0000}, {16'h0000, 16'h0001}, 16'h0000, 16'hFFFF, 16'h0100);
    wait_idle();
    chk("trunc_neg_dx0", W'(dx[0]), W'(16'hFFFF));

    // degenerate: lr = 0, then delta = 0
    issue({16'h0123, 16'hF456}, {16'h1111, 16'hE222}, 16'h0333, 16'h0280, 16'h0000);
    wait_idle();
    chk("lr0_w_new", W'(w_new), W'(32'h1111_E222));
    chk("lr0_b_new", W'(b_new), W'(16'h0333));
    issue({16'h0123, 16'hF456}, {16'h1111, 16'hE222}, 16'h0333, 16'h0000, 16'h0200);
    wait_idle();
    chk("delta0_all", W'({b_new, w_new, dx}), W'({16'h0333, 32'h1111_E222, 32'h0}));

    // start while busy: second BP at cycle 3 must be dropped
    dc = done_cnt;
    issue({16'h0300, 16'hFE00}, {16'h0100, 16'h0040}, 16'h0010, 16'h0080, 16'h0100);
    repeat (2) @(negedge clk);
    x[0] = 16'h1000; w[0] = 16'h2000; delta = 16'h0700; BP = 1'b1;
    @(negedge clk);
    BP = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);
    chk_int("busy_start_single_done", done_cnt - dc, 1);

    // reset mid-operation
    issue({16'h0200, 16'h0300}, {16'h0400, 16'h0500}, 16'h0600, 16'h0100, 16'h0100);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_clear", W'({busy, done, fsm_state, b_new, w_new, dx}), '0);
    exp_q.delete();
    exp_cyc_q.delete();
    dc = done_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    chk_int("no_done_after_reset", done_cnt - dc, 0);
    issue({16'h0200, 16'h0300}, {16'h0400, 16'h0500}, 16'h0600, 16'h0100, 16'h0100);

    // BP held high for 24 cycles: restarts every 3N+4 edges
    wait_idle();
    x = {16'h0180, 16'hFF40}; w = {16'h0220, 16'h0030}; b = 16'hFFC0;
    delta = 16'h0090; lr = 16'h0040; BP = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (k % (3*N+4) == 0) begin
        exp_q.push_back(model(x, w, b, delta, lr));
        exp_cyc_q.push_back(cyc + LAT);
      end
    end
    @(negedge clk);
    BP = 1'b0;

    // randomized operations with random idle gaps
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        rx[i*BITS +: BITS] = rnd_word();
        rw[i*BITS +: BITS] = rnd_word();
      end
      issue(rx, rw, rnd_word(), rnd_word(), rnd_word());
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    chk_int("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
